// File: rtl/uart_io_ctrl.sv
// Shares one UART between two byte-stream requesters (round-robin TX) and buffers RX bytes.
// Optional UART_IO_ECHO_EN: every received byte is echoed back out, ahead of both requesters.
module uart_io_ctrl #(
  parameter int FRAME_CYCLES = 12,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] uart_data_tx,
  output logic       uart_start,
  input  logic [7:0] uart_data_rx,
  input  logic       uart_receive_done,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overrun,
  input  logic       overrun_clr,
  output logic       tx_busy
);

  // state | meaning
  // IDLE  | arbitrating; readies may assert
  // SEND  | byte held on uart_data_tx for FRAME_CYCLES cycles
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             rcv_d;
  logic             new_byte;
  logic             arb_open;
  logic             grant0;
  logic             grant1;

`ifdef UART_IO_ECHO_EN
  logic       echo_pending;
  logic [7:0] echo_data;
  assign arb_open = (state == IDLE) && !echo_pending;
`else
  assign arb_open = (state == IDLE);
`endif

  // last_grant==1 means req1 was served last, so req0 wins a tie
  assign grant0     = arb_open & req0_valid & (~req1_valid | last_grant);
  assign grant1     = arb_open & req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign tx_busy    = (state == SEND);
  assign new_byte   = uart_receive_done & ~rcv_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      uart_data_tx <= 8'h00;
      uart_start   <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
`ifdef UART_IO_ECHO_EN
          if (echo_pending) begin
            uart_data_tx <= echo_data;
            uart_start   <= 1'b1;
            cnt          <= CNT_LOAD;
            state        <= SEND;
          end else
`endif
          if (grant0) begin
            uart_data_tx <= req0_data;
            uart_start   <= 1'b1;
            last_grant   <= 1'b0;
            cnt          <= CNT_LOAD;
            state        <= SEND;
          end else if (grant1) begin
            uart_data_tx <= req1_data;
            uart_start   <= 1'b1;
            last_grant   <= 1'b1;
            cnt          <= CNT_LOAD;
            state        <= SEND;
          end
        end
        SEND: begin
          uart_start <= 1'b0;
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rcv_d      <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      rx_overrun <= 1'b0;
    end else begin
      rcv_d <= uart_receive_done;
      if (new_byte) begin
        rx_data  <= uart_data_rx;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // a fresh overwrite beats a simultaneous clear
      if (new_byte && rx_valid && !rx_ready) rx_overrun <= 1'b1;
      else if (overrun_clr)                  rx_overrun <= 1'b0;
    end
  end

`ifdef UART_IO_ECHO_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      echo_pending <= 1'b0;
      echo_data    <= 8'h00;
    end else begin
      if (state == IDLE && echo_pending) echo_pending <= 1'b0;
      if (new_byte) begin
        echo_pending <= 1'b1;
        echo_data    <= uart_data_rx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl; TX bytes are checked against a scoreboard queue on each uart_start.
module tb_uart_io_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic [7:0] uart_data_tx;
  logic       uart_start;
  logic [7:0] uart_data_rx = 8'h00;
  logic       uart_receive_done = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       rx_overrun;
  logic       overrun_clr = 1'b0;
  logic       tx_busy;

  uart_io_ctrl #(.FRAME_CYCLES(12), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .uart_data_tx(uart_data_tx), .uart_start(uart_start),
    .uart_data_rx(uart_data_rx), .uart_receive_done(uart_receive_done),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .overrun_clr(overrun_clr), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  int         start_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       prev_start = 1'b0;
  bit         sb_on = 1'b1;
  int         base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every start pulse must carry the next queued byte
  always @(negedge clk) begin
    if (sb_on && uart_start === 1'b1) begin
      start_cnt++;
      start_t.push_back(cyc);
      check("start_width", {31'd0, prev_start}, 0);
      if (exp_q.size() == 0) check("tx_unexpected", 1, 0);
      else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", {24'd0, uart_data_tx}, {24'd0, mon_exp});
      end
    end
    prev_start = uart_start;
  end

  task automatic do_reset();
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    uart_receive_done = 1'b0; rx_ready = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("start_timeout", start_cnt >= target, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    do_reset();
    check("rst_tx", uart_data_tx, 8'h00);
    check("rst_start", uart_start, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_rxd", rx_data, 8'h00);
    check("rst_ovr", rx_overrun, 0);
    check("rst_rdy0", req0_ready, 0);

    // single send from req0
    reset = 1'b1; req0_valid = 1'b1; req0_data = 8'h41; #1;
    check("t1_rdy0", req0_ready, 1);
    check("t1_rdy1", req1_ready, 0);
    exp_q.push_back(8'h41);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      req0_data = 8'h42;
      check("t1_start", uart_start, (k == 1));
      check("t1_data", uart_data_tx, 8'h41);
      check("t1_busy", tx_busy, 1);
      check("t1_rdy_send", req0_ready, 0);
      if (k == 12) req0_valid = 1'b0;
    end
    @(negedge clk); #1;
    check("t1_idle", tx_busy, 0);
    check("t1_hold", uart_data_tx, 8'h41);

    // both requesters held: alternate, 13-cycle spacing
    do_reset();
    start_t.delete();
    base = start_cnt;
    req0_valid = 1'b1; req0_data = 8'h10;
    req1_valid = 1'b1; req1_data = 8'h20;
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    reset = 1'b1;
    wait_starts(base + 4, 70);
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (start_t.size() >= 4)
      for (int i = 1; i < 4; i++) check("t2_spacing", start_t[i] - start_t[i-1], 13);
    repeat (14) @(negedge clk);

    // reset in 5th SEND cycle aborts the frame
    do_reset();
    reset = 1'b1; req0_valid = 1'b1; req0_data = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk); req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("t3_busy5", tx_busy, 1);
    reset = 1'b0;
    @(negedge clk); #1;
    check("t3_start", uart_start, 0);
    check("t3_busy", tx_busy, 0);
    check("t3_data", uart_data_tx, 8'h00);
    reset = 1'b1; req1_valid = 1'b1; req1_data = 8'h66; #1;
    check("t3_rdy1", req1_ready, 1);
    exp_q.push_back(8'h66);
    @(negedge clk); #1;
    req1_valid = 1'b0;
    check("t3_restart", uart_start, 1);
    check("t3_data2", uart_data_tx, 8'h66);
    repeat (14) @(negedge clk);

`ifdef UART_IO_ECHO_EN
    sb_on = 1'b0;
`endif
    // RX: overwrite sets overrun, clear drops it
    uart_receive_done = 1'b1; uart_data_rx = 8'h5A;
    @(negedge clk); uart_receive_done = 1'b0; #1;
    check("rx1_valid", rx_valid, 1);
    check("rx1_data", rx_data, 8'h5A);
    check("rx1_ovr", rx_overrun, 0);
    @(negedge clk); uart_receive_done = 1'b1; uart_data_rx = 8'h33;
    @(negedge clk); uart_receive_done = 1'b0; #1;
    check("rx2_data", rx_data, 8'h33);
    check("rx2_valid", rx_valid, 1);
    check("rx2_ovr", rx_overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0; #1;
    check("rx_clr", rx_overrun, 0);
    check("rx_clr_valid", rx_valid, 1);
    rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0; #1;
    check("rx_drain", rx_valid, 0);

    // level held 3 cycles captures once
    uart_receive_done = 1'b1; uart_data_rx = 8'h77;
    @(negedge clk); uart_data_rx = 8'h78;
    @(negedge clk); uart_data_rx = 8'h79;
    @(negedge clk); uart_receive_done = 1'b0; #1;
    check("rx_hold_data", rx_data, 8'h77);
    check("rx_hold_ovr", rx_overrun, 0);
    rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0; #1;
    check("rx_hold_drain", rx_valid, 0);
    check("rx_hold_ovr2", rx_overrun, 0);

    // new byte with simultaneous read: no overrun
    uart_receive_done = 1'b1; uart_data_rx = 8'h01;
    @(negedge clk); uart_receive_done = 1'b0;
    @(negedge clk); uart_receive_done = 1'b1; uart_data_rx = 8'h02; rx_ready = 1'b1;
    @(negedge clk); uart_receive_done = 1'b0; rx_ready = 1'b0; #1;
    check("rx_rw_data", rx_data, 8'h02);
    check("rx_rw_valid", rx_valid, 1);
    check("rx_rw_ovr", rx_overrun, 0);

    // set beats clear in the same cycle
    @(negedge clk); uart_receive_done = 1'b1; uart_data_rx = 8'h03; overrun_clr = 1'b1;
    @(negedge clk); uart_receive_done = 1'b0; overrun_clr = 1'b0; #1;
    check("rx_setwin", rx_overrun, 1);
    check("rx_setwin_data", rx_data, 8'h03);

`ifdef UART_IO_ECHO_EN
    // echo has priority over a waiting requester
    do_reset();
    sb_on = 1'b1;
    start_t.delete();
    base = start_cnt;
    reset = 1'b1; uart_receive_done = 1'b1; uart_data_rx = 8'h61;
    @(negedge clk); uart_receive_done = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h99; #1;
    check("echo_rdy1", req1_ready, 0);
    exp_q.push_back(8'h61); exp_q.push_back(8'h99);
    wait_starts(base + 2, 40);
    req1_valid = 1'b0;
    if (start_t.size() >= 2) check("echo_spacing", start_t[1] - start_t[0], 13);
    repeat (14) @(negedge clk);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
